// File: rtl/montgomery_multicore_ctrl.sv
// Command controller between the ARM command/data ports and NUM_CORES Montgomery multiplier cores.
// It loads operands, launches a masked subset of cores, collects done pulses under a watchdog and returns results.
module montgomery_multicore_ctrl #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES*DATA_W-1:0] bram_din,
  input  logic                        bram_din_valid,
  output logic [NUM_CORES*DATA_W-1:0] bram_dout,
  output logic [NUM_CORES-1:0]        bram_dout_valid,
  input  logic                        bram_dout_read,
  input  logic [31:0]                 port1_din,
  input  logic                        port1_valid,
  output logic                        port1_read,
  output logic                        port2_valid,
  input  logic                        port2_read,
  output logic [NUM_CORES*DATA_W-1:0] core_a,
  output logic [NUM_CORES*DATA_W-1:0] core_b,
  output logic [NUM_CORES*DATA_W-1:0] core_m,
  output logic [NUM_CORES-1:0]        core_start,
  input  logic [NUM_CORES*DATA_W-1:0] core_result,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [1:0]                  err,
  output logic [3:0]                  leds
);

  localparam int unsigned W = NUM_CORES * DATA_W;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_MUL_START = 3'd2,
    S_MUL_WAIT  = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [1:0]            target;
  logic [NUM_CORES-1:0]  run_mask, done_mask, last_mask, newly_done, cmd_mask;
  logic [TIMEOUT_W-1:0]  watchdog;
  logic [W-1:0]          op_a, op_b, op_m, result;
  logic [3:0]            opcode;
  logic                  all_done, timeout;
  logic                  unused_din;

  assign opcode     = port1_din[3:0];
  assign cmd_mask   = port1_din[NUM_CORES+7:8];
  assign unused_din = ^{port1_din[31:NUM_CORES+8], port1_din[7:4]};
  assign newly_done = core_done & run_mask;
  assign all_done   = ((done_mask | newly_done) == run_mask);
  // Fires on the cycle whose increment would reach all-ones: exactly 2^TIMEOUT_W-1 wait cycles.
  assign timeout    = (watchdog == WD_LAST);

  assign bram_dout = result;
  assign core_a    = op_a;
  assign core_b    = op_b;
  assign core_m    = op_m;
  assign leds      = {1'b0, state};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    core_start      = '0;
    port2_valid     = 1'b0;
    bram_dout_valid = '0;
    unique case (state)
      S_IDLE: begin
        if (port1_valid) begin
          case (opcode)
            4'd0, 4'd1, 4'd2: state_next = S_READ;
            4'd3:             state_next = S_MUL_START;
            4'd4:             state_next = S_WRITE;
            default:          state_next = S_DONE;
          endcase
        end
      end
      S_READ:      if (bram_din_valid) state_next = S_DONE;
      S_MUL_START: begin
        core_start = run_mask;
        state_next = S_MUL_WAIT;
      end
      S_MUL_WAIT:  if (all_done || timeout) state_next = S_DONE;
      S_WRITE: begin
        bram_dout_valid = last_mask;
        if (bram_dout_read) state_next = S_DONE;
      end
      S_DONE: begin
        port2_valid = 1'b1;
        if (port2_read) state_next = S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port1_read <= 1'b0;
      err        <= '0;
      target     <= '0;
      run_mask   <= '0;
      done_mask  <= '0;
      last_mask  <= '1;
      watchdog   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_m       <= '0;
      result     <= '0;
    end else begin
      port1_read <= (state == S_IDLE) && port1_valid;
      unique case (state)
        S_IDLE: begin
          if (port1_valid) begin
            err    <= (opcode > 4'd4) ? 2'b01 : 2'b00;
            target <= opcode[1:0];
            if (opcode == 4'd3) run_mask <= (cmd_mask == '0) ? '1 : cmd_mask;
          end
        end
        S_READ: begin
          if (bram_din_valid) begin
            case (target)
              2'd0:    op_a <= bram_din;
              2'd1:    op_b <= bram_din;
              default: op_m <= bram_din;
            endcase
          end
        end
        S_MUL_START: begin
          done_mask <= '0;
          watchdog  <= '0;
          last_mask <= run_mask;
        end
        S_MUL_WAIT: begin
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (newly_done[i]) result[i*DATA_W +: DATA_W] <= core_result[i*DATA_W +: DATA_W];
          end
          done_mask <= done_mask | newly_done;
          watchdog  <= watchdog + 1'b1;
          if (!all_done && timeout) err <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_multicore_ctrl.sv
// Scoreboard bench for montgomery_multicore_ctrl: stimulus queues expected responses,
// a monitor pops and compares whenever the DUT presents core_start, bram_dout_valid or port2_valid.
module tb_montgomery_multicore_ctrl;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = NC * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  bram_din = '0;
  logic          bram_din_valid = 1'b0;
  logic [W-1:0]  bram_dout;
  logic [NC-1:0] bram_dout_valid;
  logic          bram_dout_read = 1'b0;
  logic [31:0]   port1_din = '0;
  logic          port1_valid = 1'b0;
  logic          port1_read;
  logic          port2_valid;
  logic          port2_read = 1'b0;
  logic [W-1:0]  core_a, core_b, core_m;
  logic [NC-1:0] core_start;
  logic [W-1:0]  core_result = '0;
  logic [NC-1:0] core_done = '0;
  logic [1:0]    err;
  logic [3:0]    leds;

  montgomery_multicore_ctrl #(.NUM_CORES(NC), .DATA_W(DW), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset),
    .bram_din(bram_din), .bram_din_valid(bram_din_valid),
    .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid), .bram_dout_read(bram_dout_read),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_valid(port2_valid), .port2_read(port2_read),
    .core_a(core_a), .core_b(core_b), .core_m(core_m),
    .core_start(core_start), .core_result(core_result), .core_done(core_done),
    .err(err), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] a, b, m, res;
    logic [7:0]  wc;
  } done_t;
  typedef struct packed {
    logic [1:0]  vmask;
    logic [31:0] dout;
  } wr_t;

  done_t      done_q[$];
  wr_t        wr_q[$];
  logic [1:0] start_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [31:0] cur_a = '0, cur_b = '0, cur_m = '0, cur_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  int   wc = 0;
  logic p2_prev = 1'b0, bv_prev = 1'b0;
  initial begin
    done_t d;
    wr_t   w;
    logic [1:0] s;
    forever begin
      @(negedge clk);
      if (reset) begin
        wc = 0; p2_prev = 1'b0; bv_prev = 1'b0;
      end else begin
        if (leds == 4'd0 || leds == 4'd2) wc = 0;
        else if (leds == 4'd3) wc++;
        if (core_start != '0) begin
          if (start_q.size() == 0) check("core_start_unexpected", core_start, 0);
          else begin s = start_q.pop_front(); check("core_start", core_start, s); end
        end
        if ((|bram_dout_valid) && !bv_prev) begin
          if (wr_q.size() == 0) check("bram_dout_valid_unexpected", bram_dout_valid, 0);
          else begin
            w = wr_q.pop_front();
            check("bram_dout_valid", bram_dout_valid, w.vmask);
            check("bram_dout", bram_dout, w.dout);
          end
        end
        if (port2_valid && !p2_prev) begin
          if (done_q.size() == 0) check("port2_valid_unexpected", port2_valid, 0);
          else begin
            d = done_q.pop_front();
            check("done_err", err, d.err);
            check("done_core_a", core_a, d.a);
            check("done_core_b", core_b, d.b);
            check("done_core_m", core_m, d.m);
            check("done_result", bram_dout, d.res);
            check("done_wait_cycles", wc, d.wc);
          end
        end
        p2_prev = port2_valid;
        bv_prev = |bram_dout_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_done(input logic [1:0] e, input logic [7:0] c);
    done_q.push_back('{err: e, a: cur_a, b: cur_b, m: cur_m, res: cur_res, wc: c});
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [7:0] mask);
    int t = 0;
    while (leds != 4'd0 && t < 50) begin tick(); t++; end
    if (t == 50) check("wait_idle", leds, 0);
    port1_din   = {16'h0, mask, 4'h0, op};
    port1_valid = 1'b1;
    tick();
    port1_valid = 1'b0;
    check("port1_read_pulse", port1_read, 1);
    check("err_on_accept", err, (op > 4'd4) ? 2'b01 : 2'b00);
  endtask

  task automatic finish_op();
    int t = 0;
    while (!port2_valid && t < 40) begin tick(); t++; end
    check("port2_valid_wait", port2_valid, 1);
    tick();
    check("port2_valid_held", port2_valid, 1);
    port2_read = 1'b1;
    tick();
    port2_read = 1'b0;
    check("port2_valid_drop", port2_valid, 0);
    check("leds_idle", leds, 0);
  endtask

  task automatic read_op(input logic [3:0] op, input logic [31:0] data);
    send_cmd(op, 8'h00);
    tick();
    check("port1_read_low", port1_read, 0);
    port1_valid = 1'b1;
    tick(); tick();
    check("port1_ignored", port1_read, 0);
    port1_valid = 1'b0;
    bram_din = data;
    bram_din_valid = 1'b1;
    tick();
    bram_din_valid = 1'b0;
    finish_op();
  endtask

  task automatic write_op(input logic [1:0] vmask);
    wr_q.push_back('{vmask: vmask, dout: cur_res});
    push_done(2'b00, 8'd0);
    send_cmd(4'd4, 8'h00);
    tick(); tick();
    check("bram_dout_valid_held", bram_dout_valid, vmask);
    bram_dout_read = 1'b1;
    tick();
    bram_dout_read = 1'b0;
    check("bram_dout_valid_drop", bram_dout_valid, 0);
    finish_op();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_leds", leds, 0);
    check("reset_port2_valid", port2_valid, 0);
    check("reset_core_start", core_start, 0);
    check("reset_bram_dout_valid", bram_dout_valid, 0);
    reset = 1'b0;
    tick();

    // Reset in the middle of MUL_WAIT with no done pulse.
    start_q.push_back(2'b11);
    send_cmd(4'd3, 8'h00);
    tick(); tick(); tick();
    check("mul_wait_before_reset", leds, 3);
    reset = 1'b1;
    #1;
    check("async_reset_leds", leds, 0);
    check("async_reset_core_start", core_start, 0);
    check("async_reset_port2_valid", port2_valid, 0);
    check("async_reset_err", err, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (20) tick();
    check("post_reset_quiet", {leds, port2_valid}, 0);

    // Write before any multiply: valid mask is all ones.
    write_op(2'b11);

    cur_a = 32'h0013_0003; push_done(2'b00, 8'd0); read_op(4'd0, cur_a);
    cur_b = 32'h0015_0005; push_done(2'b00, 8'd0); read_op(4'd1, cur_b);
    cur_m = 32'h0017_0007; push_done(2'b00, 8'd0); read_op(4'd2, cur_m);

    // Mask 0 -> both cores; core1 then core0 three cycles later.
    start_q.push_back(2'b11);
    cur_res = 32'h00AA_0055;
    push_done(2'b00, 8'd4);
    send_cmd(4'd3, 8'h00);
    tick();
    core_result = {16'h00AA, 16'hDEAD}; core_done = 2'b10;
    tick();
    core_done = 2'b00;
    tick(); tick();
    core_result = {16'hBEEF, 16'h0055}; core_done = 2'b01;
    tick();
    core_done = 2'b00;
    check("done_latency", port2_valid, 1);
    finish_op();

    write_op(2'b11);

    // Mask 0x02 with simultaneous done pulses.
    start_q.push_back(2'b10);
    cur_res = 32'h00BB_0055;
    push_done(2'b00, 8'd1);
    send_cmd(4'd3, 8'h02);
    tick();
    core_result = {16'h00BB, 16'h1111}; core_done = 2'b11;
    tick();
    core_done = 2'b00;
    check("simul_done_latency", port2_valid, 1);
    finish_op();

    // Mask 0x01, no done pulse: watchdog expires after 15 wait cycles.
    start_q.push_back(2'b01);
    push_done(2'b10, 8'd15);
    send_cmd(4'd3, 8'h01);
    finish_op();
    check("err_held_in_idle", err, 2'b10);

    cur_a = 32'h0021_0023; push_done(2'b00, 8'd0); read_op(4'd0, cur_a);

    write_op(2'b01);

    // Bad opcode.
    push_done(2'b01, 8'd0);
    send_cmd(4'd9, 8'h00);
    finish_op();

    repeat (5) tick();
    check("start_q_empty", start_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/montgomery_multicore_ctrl.md
Name: montgomery_multicore_ctrl

Overview:
Parametrised command controller between the ARM command/data ports and NUM_CORES Montgomery multiplier cores. It decodes ARM commands and loads per-core operands (A, B, M) from DMA/BRAM. It launches a masked subset of cores, collects their done pulses with a watchdog, and returns results plus a done/error handshake. Unlike the fixed two-core wrapper, it drives real start/done handshakes to the cores, does not hang on bad opcodes, and flags timeouts.

Parameters:
NUM_CORES, 2, number of multiplier cores/channels (1..8)
DATA_W, 512, operand/result width per core
TIMEOUT_W, 20, watchdog counter width; timeout fires after 2^TIMEOUT_W-1 MUL_WAIT cycles

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bram_din  in  NUM_CORES*DATA_W  operand data; slice i = core i
bram_din_valid  in  1  bram_din valid this cycle
bram_dout  out  NUM_CORES*DATA_W  result registers; slice i = core i
bram_dout_valid  out  NUM_CORES  per-core result valid
bram_dout_read  in  1  BRAM interface consumed bram_dout
port1_din  in  32  command word: [3:0] opcode, [15:8] core mask
port1_valid  in  1  command available
port1_read  out  1  command consumed (1-cycle pulse)
port2_valid  out  1  operation complete
port2_read  in  1  ARM consumed port2
core_a, core_b, core_m  out  NUM_CORES*DATA_W each  operand registers to cores
core_start  out  NUM_CORES  1-cycle start pulse per core
core_result  in  NUM_CORES*DATA_W  core results
core_done  in  NUM_CORES  1-cycle done pulse per core
err  out  2  01 bad opcode, 10 timeout, 00 ok
leds  out  4  current state encoding

Behaviour:
- Reset (async, any cycle, including mid-multiply): state IDLE. Operand/result registers, done_mask, run_mask, watchdog, err, core_start, port1_read, port2_valid and bram_dout_valid all reset to 0.
- States/leds: IDLE=0, READ=1, MUL_START=2, MUL_WAIT=3, WRITE=4, DONE=5.
- IDLE: on port1_valid, port1_read pulses high the next cycle for exactly one cycle. err clears to 00, and the opcode is decoded:
  - 0/1/2: READ with target A/B/M.
  - 3: MUL_START. run_mask = port1_din[NUM_CORES+7:8]; a zero mask means all cores.
  - 4: WRITE.
  - other: err=01, go to DONE.
- READ: wait for bram_din_valid. On the valid cycle, capture every slice into the target register set, then go to DONE.
- MUL_START (1 cycle): core_start = run_mask; clear done_mask and watchdog; go to MUL_WAIT.
- MUL_WAIT:
  - Each cycle, for every i with core_done[i] and run_mask[i]: latch core_result slice i into result[i] and set done_mask[i].
  - Simultaneous done pulses are all captured.
  - Done pulses from non-enabled cores are ignored. A second pulse from the same core overwrites its result.
  - When (done_mask | newly done) == run_mask, go to DONE the following cycle.
  - Watchdog increments each cycle. At the all-ones value, set err=10 and go to DONE; partial results are kept.
- WRITE: bram_dout_valid = run_mask from the last multiply (all ones if none has run since reset). It is held until bram_dout_read is sampled high, then drops to 0 and the FSM goes to DONE.
- DONE: port2_valid high and held until port2_read is sampled high, then IDLE. port2_valid drops the cycle after.
- bram_dout is continuously the result registers. core_a/b/m are continuously the operand registers; they are not modified during MUL_WAIT.
- port1_valid outside IDLE is ignored (not consumed).
- Latency: command accept to core_start = 2 cycles (accept cycle, MUL_START); last done to port2_valid ≤ 2 cycles.

Test Plan:
- Reset mid-MUL_WAIT (core_done never pulsed): assert reset → leds=0, core_start=0, port2_valid=0, err=00 immediately; no pulse afterwards.
- Load A=0x3, B=0x5, M=0x7 per core via opcodes 0/1/2 → each ends with port1_read 1-cycle pulse, port2_valid until port2_read; core_a slice0=0x3, core_b slice0=0x5, core_m slice0=0x7.
- Opcode 3 mask 0x00, NUM_CORES=2 → core_start=2'b11 for one cycle. Done pulses: core1 first with result 0xAA, then core0 three cycles later with 0x55 → port2_valid within 2 cycles of the second pulse. Then opcode 4 → bram_dout slice0=0x55, slice1=0xAA, bram_dout_valid=2'b11 until bram_dout_read.
- Opcode 3 mask 0x02: simultaneous core_done=2'b11 → only slice1 updated, FSM reaches DONE; slice0 result unchanged.
- Opcode 3, no done pulse, TIMEOUT_W=4 → DONE after 15 MUL_WAIT cycles, err=10. Next accepted command clears err to 00.
- Opcode 0x9 → err=01, port2_valid asserted, no core_start, FSM returns to IDLE after port2_read.
